// File: rtl/wb_trace_pkg.sv
// wb_trace_pkg: shared types and widths for the writeback retire-trace buffer
package wb_trace_pkg;

   typedef enum logic [1:0] {
      MODE_OFF       = 2'd0,
      MODE_CONT      = 2'd1,
      MODE_STOP_FULL = 2'd2,
      MODE_TRIG      = 2'd3
   } trace_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } trace_state_e;

   // Entry layout for the default 32-bit datapath; trace_w() gives the width for any XLEN
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [4:0]  rd;
      logic [31:0] data;
   } trace_entry_t;

   localparam int TRACE_W = $bits(trace_entry_t);

   function automatic int trace_w(input int xlen);
      return 32 + 32 + 5 + xlen;
   endfunction

endpackage

// File: rtl/trace_ring_mem.sv
// trace_ring_mem: DEPTH-entry trace regfile, one write port, asynchronous read at the head pointer
module trace_ring_mem
   import wb_trace_pkg::*;
#(
   parameter int W     = TRACE_W,
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          i_clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge i_clk)
      if (we) mem[waddr] <= wdata;

   assign rdata = mem[raddr];

endmodule

// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: retire-trace capture ring with trigger/stop modes and shadow copies of x1..xNUM_TAPS
module wb_trace_buffer
   import wb_trace_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int DEPTH    = 16,
   parameter int NUM_TAPS = 5,
   localparam int AW      = $clog2(DEPTH),
   localparam int CW      = $clog2(DEPTH + 1),
   localparam int EW      = trace_w(XLEN)
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_wb_vld,
   input  logic                          i_wb_we,
   input  logic [31:0]                   i_wb_pc,
   input  logic [31:0]                   i_wb_instr,
   input  logic [4:0]                    i_wb_rd,
   input  logic [XLEN-1:0]               i_wb_data,
   input  logic [1:0]                    i_mode,
   input  logic [31:0]                   i_trig_pc,
   input  logic                          i_arm,
   output logic                          o_rd_vld,
   input  logic                          i_rd_rdy,
   output logic [31:0]                   o_rd_pc,
   output logic [31:0]                   o_rd_instr,
   output logic [4:0]                    o_rd_rd,
   output logic [XLEN-1:0]               o_rd_data,
   output logic [CW-1:0]                 o_count,
   output logic                          o_overflow,
   output logic [1:0]                    o_state,
   output logic [NUM_TAPS-1:0][XLEN-1:0] o_tap
);

   trace_state_e    state_q, state_d;
   trace_mode_e     mode_q;
   logic [31:0]     trig_q;
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count;
   logic            overflow_q;
   logic            full, pop, hit, wr, drop;
   logic [EW-1:0]   rdata;

   assign full = count == CW'(DEPTH);
   assign pop  = o_rd_vld && i_rd_rdy;
   assign hit  = i_wb_vld && (i_wb_pc == trig_q);
   assign wr   = !i_arm && ((state_q == ST_CAPTURE && i_wb_vld) || (state_q == ST_ARMED && hit));
   // Only continuous mode can be full while capturing, so a full write without a pop overwrites the oldest
   assign drop = wr && full && !pop;

   always_comb begin
      state_d = state_q;
      if (i_arm)
         state_d = i_mode == MODE_OFF ? ST_IDLE : i_mode == MODE_TRIG ? ST_ARMED : ST_CAPTURE;
      else if (state_q == ST_ARMED && hit)
         state_d = ST_CAPTURE;
      else if (wr && !pop && mode_q != MODE_CONT && count == CW'(DEPTH - 1))
         state_d = ST_DONE;
   end

   always_ff @(posedge i_clk)
      if (!i_rst) state_q <= ST_IDLE;
      else state_q <= state_d;

   always_ff @(posedge i_clk)
      if (!i_rst) begin
         mode_q     <= MODE_OFF;
         trig_q     <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         overflow_q <= 1'b0;
      end else if (i_arm) begin
         mode_q     <= trace_mode_e'(i_mode);
         trig_q     <= i_trig_pc;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (wr) wr_ptr <= wr_ptr + AW'(1);
         if (pop || drop) rd_ptr <= rd_ptr + AW'(1);
         if (wr && !pop && !full) count <= count + CW'(1);
         else if (!wr && pop) count <= count - CW'(1);
         if (drop || (state_q == ST_DONE && i_wb_vld && full && !pop)) overflow_q <= 1'b1;
      end

   always_ff @(posedge i_clk)
      if (!i_rst) o_tap <= '0;
      else
         for (int k = 0; k < NUM_TAPS; k++)
            if (i_wb_vld && i_wb_we && i_wb_rd == 5'(k + 1)) o_tap[k] <= i_wb_data;

   trace_ring_mem #(.W(EW), .DEPTH(DEPTH)) u_mem (
      .i_clk (i_clk),
      .we    (wr),
      .waddr (wr_ptr),
      .wdata ({i_wb_pc, i_wb_instr, i_wb_rd, i_wb_data}),
      .raddr (rd_ptr),
      .rdata (rdata)
   );

   assign {o_rd_pc, o_rd_instr, o_rd_rd, o_rd_data} = rdata;
   assign o_rd_vld   = count != '0;
   assign o_count    = count;
   assign o_overflow = overflow_q;
   assign o_state    = state_q;

endmodule
